// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clock-divider scheduler and its counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clkdiv_pkg;

  localparam int unsigned DIV_W_DEF       = 25;
  localparam int unsigned DEFAULT_DIV_DEF = 2499;
  localparam int unsigned TICK_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clkdiv_counter.sv
// Loadable down-counter with a terminal (==0) flag; saturates at zero.
// Latency: load/decrement visible one clk_in cycle later; terminal_o is combinational from the count register.
// Backpressure: none; load_i takes priority over dec_i.
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int unsigned W = DIV_W_DEF
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         terminal_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement but never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset to zero.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal_o = (cnt_q == '0);

endmodule

// File: rtl/clkdiv_scheduler.sv
// Run/stop and glitch-free reconfiguration controller for the square-wave divider (optional CLKDIV_TICK_COUNT_EN adds tick_count).
// Latency: clk_out/tick registered; a pending divide value takes effect at the next 1->0 boundary (next cycle when idle).
// Backpressure: cfg_ready drops while one value is pending; the offer must be held until accepted.
module clkdiv_scheduler
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] active_div
`ifdef CLKDIV_TICK_COUNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_count
`endif
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

  state_e           state_q, state_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;

  logic             cnt_load;
  logic [DIV_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_term;
  logic             drain_stop;

`ifdef CLKDIV_TICK_COUNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
`endif

  clkdiv_counter #(
    .W (DIV_W)
  ) u_cnt (
    .clk_in     (clk_in),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .terminal_o (cnt_term)
  );

  // FSM next state, pending-slot handshake and counter control.
  // In DRAIN, a re-asserted en makes the cycle behave exactly like RUN,
  // so a terminal count in that cycle toggles normally instead of stopping.
  always_comb begin
    state_d      = state_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    active_d     = active_q;
    pend_vld_d   = pend_vld_q;
    pend_div_d   = pend_div_q;
    cnt_load     = 1'b0;
    cnt_load_val = active_q;
    cnt_dec      = 1'b0;
    drain_stop   = 1'b0;

    if (cfg_valid && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_div_d = cfg_div;
    end

    case (state_q)
      IDLE: begin
        clk_out_d = 1'b0;
        if (pend_vld_q) begin
          active_d   = pend_div_q;
          pend_vld_d = 1'b0;
        end
        if (en) begin
          state_d      = RUN;
          cnt_load     = 1'b1;
          cnt_load_val = pend_vld_q ? pend_div_q : active_q;
        end
      end
      RUN, DRAIN: begin
        drain_stop = (state_q == DRAIN) && !en;
        state_d    = en ? RUN : DRAIN;
        if (!cnt_term) begin
          cnt_dec = 1'b1;
        end else if (!clk_out_q) begin
          if (drain_stop) begin
            state_d = IDLE;
          end else begin
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
            cnt_load  = 1'b1;
          end
        end else begin
          // Falling edge closes a full period: the only safe point to swap.
          clk_out_d = 1'b0;
          cnt_load  = 1'b1;
          if (pend_vld_q) begin
            active_d     = pend_div_q;
            cnt_load_val = pend_div_q;
            pend_vld_d   = 1'b0;
          end
          if (drain_stop) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        clk_out_d = 1'b0;
      end
    endcase
  end

`ifdef CLKDIV_TICK_COUNT_EN
  // Rising-edge counter; wraps naturally and only moves when a tick fires.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_d) begin
      tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_count = tick_cnt_q;
`endif

  // State, output and configuration registers; reset aborts any run at once.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      active_q   <= RST_DIV;
      pend_vld_q <= 1'b0;
      pend_div_q <= '0;
    end else begin
      state_q    <= state_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      active_q   <= active_d;
      pend_vld_q <= pend_vld_d;
      pend_div_q <= pend_div_d;
    end
  end

  assign cfg_ready  = !pend_vld_q;
  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign busy       = (state_q != IDLE);
  assign active_div = active_q;

endmodule

// File: tb/tb_clkdiv_scheduler.sv
// Self-checking bench: directed vector table, hand sequences, and random run against a reference model.
// Latency: expectations taken 1 time unit after each rising clk_in edge.
// Backpressure: offered cfg values are held until the model says they were accepted.
module tb_clkdiv_scheduler;

  localparam int DW = 8;
  localparam int DD = 3;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic          cfg_ready;
  logic          clk_out;
  logic          tick;
  logic          busy;
  logic [DW-1:0] active_div;
`ifdef CLKDIV_TICK_COUNT_EN
  logic [15:0]   tick_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  clkdiv_scheduler #(
    .DIV_W       (DW),
    .DEFAULT_DIV (DD)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy),
    .active_div (active_div)
`ifdef CLKDIV_TICK_COUNT_EN
    ,
    .tick_count (tick_count)
`endif
  );

  typedef struct {
    bit            r;
    bit            e;
    bit            cv;
    logic [DW-1:0] cd;
    bit            x_clk;
    bit            x_tick;
    bit            x_busy;
    bit            x_rdy;
    logic [DW-1:0] x_act;
  } vec_t;

  vec_t tbl[35];

  function automatic vec_t mk(input bit r, e, cv, input int cd,
                              input bit xc, xt, xb, xr, input int xa);
    vec_t v;
    v.r = r; v.e = e; v.cv = cv; v.cd = DW'(cd);
    v.x_clk = xc; v.x_tick = xt; v.x_busy = xb; v.x_rdy = xr; v.x_act = DW'(xa);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input bit xc, xt, xb, xr, input logic [DW-1:0] xa);
    chk({tag, ".clk_out"},    32'(clk_out),    32'(xc));
    chk({tag, ".tick"},       32'(tick),       32'(xt));
    chk({tag, ".busy"},       32'(busy),       32'(xb));
    chk({tag, ".cfg_ready"},  32'(cfg_ready),  32'(xr));
    chk({tag, ".active_div"}, 32'(active_div), 32'(xa));
  endtask

  task automatic drv(input bit r, e, cv, input logic [DW-1:0] cd);
    rst = r; en = e; cfg_valid = cv; cfg_div = cd;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Steps until tick is seen; n = cycles taken, ok = seen within budget.
  task automatic wait_tick(input int max, output int n, output bit ok);
    ok = 1'b0;
    n  = max;
    for (int i = 1; i <= max; i++) begin
      step();
      if (tick === 1'b1) begin
        n  = i;
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Reference model: level + remaining cycles in the current half-period.
  bit m_idle = 1'b1, m_drain = 1'b0, m_lvl = 1'b0, m_tick = 1'b0, m_pv = 1'b0;
  int m_rem = 0, m_act = DD, m_pend = 0, m_tc = 0;

  task automatic m_step(input bit r, e, cv, input int cd);
    bit take;
    bit halt;
    if (r) begin
      m_idle = 1'b1; m_drain = 1'b0; m_lvl = 1'b0; m_tick = 1'b0; m_pv = 1'b0;
      m_rem = 0; m_act = DD; m_pend = 0; m_tc = 0;
      return;
    end
    take   = cv && !m_pv;
    m_tick = 1'b0;
    if (m_idle) begin
      if (m_pv) begin m_act = m_pend; m_pv = 1'b0; end
      if (e) begin m_idle = 1'b0; m_drain = 1'b0; m_rem = m_act; end
    end else begin
      halt    = m_drain && !e;
      m_drain = !e;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end else if (!m_lvl) begin
        if (halt) m_idle = 1'b1;
        else begin
          m_lvl = 1'b1; m_tick = 1'b1; m_tc = (m_tc + 1) % 65536; m_rem = m_act;
        end
      end else begin
        m_lvl = 1'b0;
        if (m_pv) begin m_act = m_pend; m_pv = 1'b0; end
        m_rem = m_act;
        if (halt) m_idle = 1'b1;
      end
    end
    if (take) begin m_pv = 1'b1; m_pend = cd; end
  endtask

  initial begin
    int  n;
    bit  ok;
    bit  r_e;
    bit  ov;
    int  od;
    bit  rr;
    bit  was_rdy;

    // r  e  cv cd   clk tick busy rdy act
    tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 1, 3);
    tbl[1]  = mk(0, 1, 0, 0,  0, 0, 1, 1, 3);
    tbl[2]  = mk(0, 1, 0, 0,  0, 0, 1, 1, 3);
    tbl[3]  = mk(0, 1, 0, 0,  0, 0, 1, 1, 3);
    tbl[4]  = mk(0, 1, 0, 0,  0, 0, 1, 1, 3);
    tbl[5]  = mk(0, 1, 0, 0,  1, 1, 1, 1, 3);
    tbl[6]  = mk(0, 1, 0, 0,  1, 0, 1, 1, 3);
    tbl[7]  = mk(0, 1, 0, 0,  1, 0, 1, 1, 3);
    tbl[8]  = mk(0, 1, 0, 0,  1, 0, 1, 1, 3);
    tbl[9]  = mk(0, 1, 0, 0,  0, 0, 1, 1, 3);
    tbl[10] = mk(0, 1, 0, 0,  0, 0, 1, 1, 3);
    tbl[11] = mk(0, 1, 0, 0,  0, 0, 1, 1, 3);
    tbl[12] = mk(0, 1, 0, 0,  0, 0, 1, 1, 3);
    tbl[13] = mk(0, 1, 0, 0,  1, 1, 1, 1, 3);
    tbl[14] = mk(0, 1, 1, 1,  1, 0, 1, 0, 3);
    tbl[15] = mk(0, 1, 1, 1,  1, 0, 1, 0, 3);
    tbl[16] = mk(0, 1, 0, 0,  1, 0, 1, 0, 3);
    tbl[17] = mk(0, 1, 0, 0,  0, 0, 1, 1, 1);
    tbl[18] = mk(0, 1, 0, 0,  0, 0, 1, 1, 1);
    tbl[19] = mk(0, 1, 0, 0,  1, 1, 1, 1, 1);
    tbl[20] = mk(0, 1, 0, 0,  1, 0, 1, 1, 1);
    tbl[21] = mk(0, 1, 0, 0,  0, 0, 1, 1, 1);
    tbl[22] = mk(0, 1, 0, 0,  0, 0, 1, 1, 1);
    tbl[23] = mk(0, 1, 0, 0,  1, 1, 1, 1, 1);
    tbl[24] = mk(0, 0, 0, 0,  1, 0, 1, 1, 1);
    tbl[25] = mk(0, 0, 0, 0,  0, 0, 0, 1, 1);
    tbl[26] = mk(0, 0, 0, 0,  0, 0, 0, 1, 1);
    tbl[27] = mk(0, 0, 1, 0,  0, 0, 0, 0, 1);
    tbl[28] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
    tbl[29] = mk(0, 1, 0, 0,  0, 0, 1, 1, 0);
    tbl[30] = mk(0, 1, 0, 0,  1, 1, 1, 1, 0);
    tbl[31] = mk(0, 1, 0, 0,  0, 0, 1, 1, 0);
    tbl[32] = mk(0, 1, 0, 0,  1, 1, 1, 1, 0);
    tbl[33] = mk(0, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[34] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);

    for (int i = 0; i < 35; i++) begin
      drv(tbl[i].r, tbl[i].e, tbl[i].cv, tbl[i].cd);
      step();
      cmp_all($sformatf("vec%0d", i), tbl[i].x_clk, tbl[i].x_tick,
              tbl[i].x_busy, tbl[i].x_rdy, tbl[i].x_act);
    end

    // en pulsed low for two cycles inside a high phase must not disturb the period.
    drv(1, 0, 0, 0); step();
    drv(0, 1, 0, 0);
    wait_tick(20, n, ok);
    chk("t4_first_rise_ok", 32'(ok), 32'd1);
    drv(0, 0, 0, 0); step();
    chk("t4_clk_held_1", 32'(clk_out), 32'd1);
    step();
    chk("t4_clk_held_2", 32'(clk_out), 32'd1);
    chk("t4_busy_held", 32'(busy), 32'd1);
    drv(0, 1, 0, 0);
    wait_tick(20, n, ok);
    chk("t4_period", 32'(n + 2), 32'd8);

    // Reset in the high phase with a value pending: everything returns to defaults.
    drv(0, 1, 1, 5); step();
    chk("t6_pending_rdy", 32'(cfg_ready), 32'd0);
    chk("t6_pre_clk", 32'(clk_out), 32'd1);
    drv(1, 1, 1, 5); step();
    cmp_all("t6_rst", 1'b0, 1'b0, 1'b0, 1'b1, DW'(DD));
`ifdef CLKDIV_TICK_COUNT_EN
    chk("t6_tick_count_rst", 32'(tick_count), 32'd0);
`endif
    drv(0, 1, 0, 0);
    wait_tick(20, n, ok);
    chk("t6_first_rise_latency", 32'(n), 32'd5);
    for (int k = 0; k < 4; k++) begin
      wait_tick(20, n, ok);
      chk("t6_rise_interval", 32'(n), 32'd8);
    end
`ifdef CLKDIV_TICK_COUNT_EN
    chk("t6_tick_count_5", 32'(tick_count), 32'd5);
`endif

    // Random run against the reference model.
    drv(1, 0, 0, 0); m_step(1, 0, 0, 0); step();
    r_e = 1'b0; ov = 1'b0; od = 0;
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) r_e = !r_e;
      if (!ov && ($urandom_range(0, 9) == 0)) begin
        ov = 1'b1;
        od = int'($urandom_range(0, 4));
      end
      was_rdy = !m_pv;
      drv(rr, r_e, ov, DW'(od));
      m_step(rr, r_e, ov, od);
      step();
      cmp_all("rand", m_lvl, m_tick, !m_idle, !m_pv, DW'(m_act));
`ifdef CLKDIV_TICK_COUNT_EN
      chk("rand.tick_count", 32'(tick_count), 32'(m_tc));
`endif
      if (ov && was_rdy && !rr) ov = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
